// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the step-pulse generator: FSM encodings, default
// timing constants and a counter-width helper.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_STEP  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_DISTANCE  = 10;
  localparam int unsigned DEFAULT_DB_CYCLES = 4;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_step_gen_if.sv
// Button inputs and step-pulse outputs of pulse_step_gen, grouped as one bundle.
interface pulse_step_gen_if;
  logic btn_mode;
  logic btn_step;
  logic pulse;
  logic running;

  modport master (output btn_mode, output btn_step, input pulse, input running);
  modport slave  (input btn_mode, input btn_step, output pulse, output running);
endinterface

// File: rtl/button_debouncer.sv
// Raw push-button conditioner: 2-FF synchroniser, stability filter and a
// registered one-cycle strobe on each accepted press.
module button_debouncer
  import pulse_gen_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = cnt_width(DB_CYCLES - 1);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;

  // Accept a new level only after DB_CYCLES consecutive mismatching samples.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync_q != level_q) begin
      if (db_cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync_q;
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      meta_q   <= raw;
      sync_q   <= meta_q;
      level_q  <= level_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/pulse_step_gen.sv
// Step-pulse generator feeding the Gray counter: periodic pulse in RUN, frozen in
// PAUSE, single pulse per step press. Single-step path built only with STEPGEN_SINGLE_STEP_EN.
module pulse_step_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned DISTANCE  = DEFAULT_DISTANCE,
  parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  pulse_step_gen_if.slave bus
);

  localparam int unsigned CW = cnt_width(DISTANCE);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          running_q, running_d;
  logic          mode_press;
  logic          unused_mode_level;

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_mode),
    .level (unused_mode_level),
    .press (mode_press)
  );

`ifdef STEPGEN_SINGLE_STEP_EN
  logic step_press;
  logic unused_step_level;

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_step),
    .level (unused_step_level),
    .press (step_press)
  );
`else
  logic unused_btn_step;
  assign unused_btn_step = bus.btn_step;
`endif

  // Mode press always wins over a coincident step press.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (mode_press) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (mode_press) begin
          state_d = ST_RUN;
        end
`ifdef STEPGEN_SINGLE_STEP_EN
        else if (step_press) begin
          state_d = ST_STEP;
        end
`endif
      end
`ifdef STEPGEN_SINGLE_STEP_EN
      ST_STEP:  state_d = mode_press ? ST_RUN : ST_PAUSE;
`endif
      default:  state_d = ST_RUN;
    endcase
  end

  // Period counter advances only in RUN, so a resume continues where it froze.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_RUN) begin
      cnt_d = (cnt_q == CW'(DISTANCE)) ? '0 : cnt_q + CW'(1);
    end
    pulse_d = (state_q == ST_RUN) && (cnt_q == CW'(DISTANCE));
`ifdef STEPGEN_SINGLE_STEP_EN
    if (state_q == ST_STEP) begin
      pulse_d = 1'b1;
    end
`endif
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      running_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      running_q <= running_d;
    end
  end

  assign bus.pulse   = pulse_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_pulse_step_gen.sv
// Self-checking bench for pulse_step_gen (DISTANCE=10, DB_CYCLES=4); step-path
// expectations follow STEPGEN_SINGLE_STEP_EN.
module tb_pulse_step_gen;
  import pulse_gen_pkg::*;

  localparam int unsigned DIST = 10;
  localparam int unsigned DB   = 4;

  typedef struct {
    logic mode;
    logic step;
    logic exp_pulse;
    logic exp_running;
  } vec_t;

  typedef struct {
    logic  pulse;
    logic  running;
    int    idx;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  pulse_step_gen_if bus ();

  pulse_step_gen #(.DISTANCE(DIST), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_bit(input string name, input int idx, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s idx=%0d got=%b exp=%b", name, idx, got, exp);
  endtask

  // Vector index i: inputs applied after edge i, outputs checked after edge i+1.
  task automatic build(input int n);
    vec_t v;
    v = '{mode: 1'b0, step: 1'b0, exp_pulse: 1'b0, exp_running: 1'b1};
    vecs.delete();
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic set_mode(input int a, input int b);
    for (int i = a; i <= b; i++) vecs[i].mode = 1'b1;
  endtask

  task automatic set_step(input int a, input int b);
    for (int i = a; i <= b; i++) vecs[i].step = 1'b1;
  endtask

  task automatic set_running(input int a, input int b, input logic val);
    for (int i = a; i <= b; i++) vecs[i].exp_running = val;
  endtask

  task automatic set_pulse(input int i);
    vecs[i].exp_pulse = 1'b1;
  endtask

  task automatic run_vecs(input string tag);
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.btn_mode = vecs[i].mode;
      bus.btn_step = vecs[i].step;
      sb_q.push_back('{pulse: vecs[i].exp_pulse, running: vecs[i].exp_running, idx: i, tag: tag});
      @(posedge clk);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s scoreboard empty at idx=%0d", tag, i);
      end else begin
        e = sb_q.pop_front();
        check_bit({e.tag, ".pulse"}, e.idx, bus.pulse, e.pulse);
        check_bit({e.tag, ".running"}, e.idx, bus.running, e.running);
      end
    end
  endtask

  // Assert reset between edges; outputs must snap to reset values at once.
  task automatic reset_pulse(input string tag);
    #2;
    rst          = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_step = 1'b0;
    #1;
    check_bit({tag, ".pulse"}, -1, bus.pulse, 1'b0);
    check_bit({tag, ".running"}, -1, bus.running, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_step = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_bit("reset.pulse", -1, bus.pulse, 1'b0);
    check_bit("reset.running", -1, bus.running, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Free run, pause/resume, glitch rejection, step, simultaneous press.
    build(206);
    set_mode(40, 51);
    set_mode(70, 77);
    set_mode(100, 102);
    set_mode(110, 110);
    set_mode(112, 112);
    set_mode(130, 137);
    set_mode(180, 187);
    set_step(150, 169);
    set_step(180, 187);
    set_running(46, 75, 1'b0);
    set_running(136, 185, 1'b0);
    set_pulse(10);
    set_pulse(21);
    set_pulse(32);
    set_pulse(43);
    set_pulse(84);   // frozen cnt=3 resumes: 7 more counts then pulse
    set_pulse(95);
    set_pulse(106);
    set_pulse(117);
    set_pulse(128);
`ifdef STEPGEN_SINGLE_STEP_EN
    set_pulse(157);  // step pulse 8 cycles after raw rise at 150
`endif
    set_pulse(189);  // resume from cnt=8
    set_pulse(200);
    run_vecs("main");

    // Reset mid-RUN with cnt=5.
    reset_pulse("rst_run");

    // Pause, then a partial step press cut short by reset.
    build(13);
    set_mode(0, 7);
    set_step(10, 12);
    set_running(6, 12, 1'b0);
    run_vecs("pause");
    reset_pulse("rst_pause");

    // Reset during an active pulse.
    build(11);
    set_pulse(10);
    run_vecs("to_pulse");
    reset_pulse("rst_pulse");

    // Clean restart after all aborts.
    build(35);
    set_pulse(10);
    set_pulse(21);
    set_pulse(32);
    run_vecs("restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_step_gen.md
# pulse_step_gen

Step-pulse generator that sits directly upstream of the Gray counter system. It produces the single-cycle `pulse` enable that advances the counter once every DISTANCE+1 clocks. It also gives the board user run/pause and single-step control from two raw push-buttons, with synchronisation and debounce built in. The counter stage consumes `pulse` as its only advance condition.

## Interface
- DISTANCE, 10: idle cycles between pulses; pulse period = DISTANCE+1 clocks; DISTANCE ≥ 0.
- DB_CYCLES, 4: consecutive stable synchronised samples required before a button level is accepted; DB_CYCLES ≥ 1.
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- btn_mode  input  1  raw asynchronous run/pause button, active-high.
- btn_step  input  1  raw asynchronous single-step button, active-high.
- pulse  output  1  one-cycle advance enable to the Gray counter, registered.
- running  output  1  1 in RUN, 0 in PAUSE and STEP, registered.

## Operation
- Each button path: 2-FF synchroniser, then debounce counter.
  - The filtered level takes a new value only after the synchronised level has differed from it for DB_CYCLES consecutive edges.
  - Any mismatch-free sample clears the debounce count.
  - A rising edge of the filtered level yields a one-cycle `*_press` strobe.
- FSM states: RUN, PAUSE, STEP. Reset state: RUN.
  - RUN: `mode_press` → PAUSE. `step_press` is ignored.
  - PAUSE: `mode_press` → RUN. `step_press` (without `mode_press`) → STEP.
  - STEP: `pulse` is set for exactly one cycle. Next state is PAUSE, or RUN if `mode_press` occurs in this cycle (the pulse is still issued).
- Period counter `cnt`, width $clog2(DISTANCE+1) (minimum 1 bit), reset 0.
  - In RUN: `cnt` ← (`cnt`==DISTANCE) ? 0 : `cnt`+1.
  - In PAUSE/STEP: `cnt` holds. Resuming continues from the held value.
- `pulse` ← (state==RUN && `cnt`==DISTANCE) || state==STEP.
- Simultaneous `mode_press` and `step_press` in PAUSE: mode wins. Go to RUN; the step is dropped.

## Timing
- Reset values: `pulse`=0, `running`=1, `cnt`=0, synchronisers and filtered levels 0, debounce counters 0.
- While `rst` is high, all outputs are held at reset values immediately, with no clock dependency.
- First `pulse` after reset release is high during the cycle following edge DISTANCE+1. Subsequent pulses come every DISTANCE+1 cycles.
- DISTANCE=0: `pulse` is continuously high in RUN.
- Button latency, for a raw level held stable: `running` changes DB_CYCLES+3 cycles after the raw rise. A step pulse appears DB_CYCLES+4 cycles after the raw rise.
- A raw press shorter than DB_CYCLES cycles (after synchronisation) produces no strobe.
- Held buttons produce one strobe only. A new strobe requires an accepted release followed by an accepted press.
- `rst` asserted mid-operation, including mid-debounce or in STEP, aborts everything. No pulse is emitted and no pending press survives.

## Configuration
- STEPGEN_SINGLE_STEP_EN defined: the single-step path and STEP state exist as described.
- STEPGEN_SINGLE_STEP_EN undefined:
  - The `btn_step` port remains but is ignored.
  - Its debouncer is not instantiated.
  - STEP is unreachable; the FSM has RUN/PAUSE only.
  - In PAUSE, `pulse` stays 0.

## Structure
- Shared package `pulse_gen_pkg`: FSM state encodings (RUN=2'd0, PAUSE=2'd1, STEP=2'd2) and default DISTANCE/DB_CYCLES constants, also reused by the system-level bench.
- Sub-module `button_debouncer`, instantiated per button.
  - Parameter: DB_CYCLES.
  - Ports: clk, rst, raw, level, press.
  - Contains the synchroniser, debounce counter and edge detector.
- Top level holds the FSM, period counter and output registers.

## Test plan
All scenarios use DISTANCE=10, DB_CYCLES=4.
- Reset release, no buttons → `running`=1. `pulse` high for 1 cycle at cycles 11, 22, 33 after release, 0 elsewhere.
- `btn_mode` held high for 12 cycles → `running` falls 7 cycles after the raw rise and pulses stop. A second press resumes, and the next pulse arrives after the remaining count (frozen `cnt` honoured).
- `btn_mode` glitch high for 3 cycles, plus a bouncing 1-0-1-0 pattern → no state change, `running` stays 1.
- In PAUSE, `btn_step` press → exactly one `pulse` 8 cycles after the raw rise. `running` stays 0. Holding the button gives no further pulses.
- In PAUSE, `btn_mode` and `btn_step` rise on the same cycle → RUN entered, no step pulse. Next pulse at the resumed count.
- `rst` pulsed mid-RUN at `cnt`=5 → `pulse`=0 and `running`=1 immediately. After release, the first pulse is at cycle 11. Repeat in the build without STEPGEN_SINGLE_STEP_EN: `btn_step` has no effect.
